// File: rtl/seq_shift_mul_pkg.sv
// Shared encodings for the sequential shift/multiply unit.
package seq_shift_mul_pkg;

  localparam int unsigned OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_LSL = 2'b00,
    OP_LSR = 2'b01,
    OP_ASR = 2'b10,
    OP_MUL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  function automatic logic is_mul(input op_e op);
    return op == OP_MUL;
  endfunction

endpackage

// File: rtl/shift_mul_step.sv
// One iteration of the shift/multiply datapath: a single-bit shift, or one
// shift-and-add step of an unsigned multiply over the {hi,lo} pair.
module shift_mul_step
  import seq_shift_mul_pkg::*;
#(
  parameter int unsigned N = 64
) (
  input  op_e          op,
  input  logic [N-1:0] hi,
  input  logic [N-1:0] lo,
  input  logic [N-1:0] a,
  input  logic         sign,
  output logic [N-1:0] hi_nxt,
  output logic [N-1:0] lo_nxt
);

  logic [N:0] sum;

  always_comb begin
    hi_nxt = hi;
    lo_nxt = lo;
    sum    = '0;
    case (op)
      OP_LSL: lo_nxt = {lo[N-2:0], 1'b0};
      OP_LSR: lo_nxt = {1'b0, lo[N-1:1]};
      OP_ASR: lo_nxt = {sign, lo[N-1:1]};
      OP_MUL: begin
        // Add the multiplicand when the current multiplier bit is set, then
        // shift the whole {carry,hi,lo} right by one.
        sum    = (N+1)'(hi) + (N+1)'(lo[0] ? a : '0);
        hi_nxt = sum[N:1];
        lo_nxt = {sum[0], lo[N-1:1]};
      end
      default: begin
        hi_nxt = hi;
        lo_nxt = lo;
      end
    endcase
  end

endmodule

// File: rtl/seq_shift_mul_unit.sv
// Multi-cycle LSL/LSR/ASR and unsigned NxN->2N multiply with a
// start/busy/done handshake; shifts run one bit per cycle.
module seq_shift_mul_unit
  import seq_shift_mul_pkg::*;
#(
  parameter int unsigned N = 64
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] F,
  output logic [N-1:0] Fhi
);

  localparam int unsigned SHW = $clog2(N);
  localparam int unsigned CW  = SHW + 1;

  state_e       state;
  op_e          op_q;
  logic [N-1:0] a_q;
  logic [CW-1:0] cnt;
  logic [N-1:0] hi;
  logic [N-1:0] lo;
  logic [N-1:0] hi_nxt;
  logic [N-1:0] lo_nxt;
  op_e          op_in;

  assign op_in = op_e'(op);

  shift_mul_step #(.N(N)) u_step (
    .op     (op_q),
    .hi     (hi),
    .lo     (lo),
    .a      (a_q),
    .sign   (a_q[N-1]),
    .hi_nxt (hi_nxt),
    .lo_nxt (lo_nxt)
  );

  // Control FSM; the lo register doubles as the shift work register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      op_q  <= OP_LSL;
      a_q   <= '0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      F     <= '0;
      Fhi   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            op_q  <= op_in;
            a_q   <= A;
            cnt   <= is_mul(op_in) ? CW'(N) : CW'(B[SHW-1:0]);
            hi    <= '0;
            lo    <= is_mul(op_in) ? B : A;
            busy  <= 1'b1;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (cnt != '0) begin
            hi  <= hi_nxt;
            lo  <= lo_nxt;
            cnt <= cnt - CW'(1);
          end else begin
            F     <= lo;
            Fhi   <= hi;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
